// File: rtl/qs_bank_sched.sv
// qs_bank_sched: per-bank lifecycle state shared by enqueue, sort and dequeue agents.
// Define QS_BANK_SCHED_LEGAL_CHK_EN to drop writes that skip or reverse the lifecycle.
module qs_bank_sched #(
    parameter  int BANKS_N = 4,
    parameter  int N_W     = 10,
    localparam int IW      = $clog2(BANKS_N),
    localparam int SW      = N_W + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] enq_bank_idx,
    input  logic [IW-1:0] srt_bank_idx,
    input  logic [IW-1:0] deq_bank_idx,
    input  logic          enq_upd_vld,
    input  logic          srt_upd_vld,
    input  logic          deq_upd_vld,
    input  logic [SW-1:0] enq_upd,
    input  logic [SW-1:0] srt_upd,
    input  logic [SW-1:0] deq_upd,
    output logic [SW-1:0] enq_bank_r,
    output logic [SW-1:0] srt_bank_r,
    output logic [SW-1:0] deq_bank_r,
    output logic [IW:0]   occ_r,
    output logic          empty_r,
    output logic          full_r,
    output logic          err_r
);

    typedef logic [IW-1:0] bank_id_t;

    typedef struct packed {
        logic           err;
        logic [N_W-1:0] n;
        logic [2:0]     status;
    } bank_state_t;

    typedef enum logic [1:0] {
        WR_DEQ,
        WR_SRT,
        WR_ENQ
    } writer_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOADING   = 3'd1;
    localparam logic [2:0] ST_READY     = 3'd2;
    localparam logic [2:0] ST_SORTING   = 3'd3;
    localparam logic [2:0] ST_SORTED    = 3'd4;
    localparam logic [2:0] ST_UNLOADING = 3'd5;

`ifdef QS_BANK_SCHED_LEGAL_CHK_EN
    localparam bit LEGAL_CHK = 1'b1;
`else
    localparam bit LEGAL_CHK = 1'b0;
`endif

    bank_state_t bank_q   [BANKS_N];
    bank_state_t bank_nxt [BANKS_N];
    bank_state_t upd;
    writer_e     wr;
    logic        hit_e;
    logic        hit_s;
    logic        hit_d;
    logic        err_set;
    logic [IW:0] occ_nxt;

    function automatic logic accept(
        input writer_e    w,
        input logic [2:0] cur,
        input logic [2:0] nxt
    );
        logic legal;
        legal = 1'b0;
        unique case (w)
            WR_ENQ: legal = (cur == ST_IDLE    && nxt == ST_LOADING) ||
                            (cur == ST_LOADING && nxt == ST_READY);
            WR_SRT: legal = (cur == ST_READY   && nxt == ST_SORTING) ||
                            (cur == ST_SORTING && nxt == ST_SORTED);
            WR_DEQ: legal = (cur == ST_SORTED    && nxt == ST_UNLOADING) ||
                            (cur == ST_UNLOADING && nxt == ST_IDLE);
            default: legal = 1'b0;
        endcase
        // Codes 6-7 are rejected even when lifecycle checking is compiled out
        return (nxt <= ST_UNLOADING) && (legal || !LEGAL_CHK);
    endfunction

    always_comb begin
        bank_nxt = bank_q;
        err_set  = 1'b0;
        occ_nxt  = '0;
        hit_e    = 1'b0;
        hit_s    = 1'b0;
        hit_d    = 1'b0;
        wr       = WR_ENQ;
        upd      = '0;
        for (int b = 0; b < BANKS_N; b++) begin
            hit_e = enq_upd_vld && (enq_bank_idx == bank_id_t'(b));
            hit_s = srt_upd_vld && (srt_bank_idx == bank_id_t'(b));
            hit_d = deq_upd_vld && (deq_bank_idx == bank_id_t'(b));
            if ((hit_d && (hit_s || hit_e)) || (hit_s && hit_e))
                err_set = 1'b1;
            wr  = WR_ENQ;
            upd = enq_upd;
            if (hit_d) begin
                wr  = WR_DEQ;
                upd = deq_upd;
            end else if (hit_s) begin
                wr  = WR_SRT;
                upd = srt_upd;
            end
            if (hit_d || hit_s || hit_e) begin
                if (accept(wr, bank_q[b].status, upd.status))
                    bank_nxt[b] = upd;
                else
                    err_set = 1'b1;
            end
            if (bank_nxt[b].status != ST_IDLE)
                occ_nxt = occ_nxt + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS_N; b++)
                bank_q[b] <= '0;
            enq_bank_r <= '0;
            srt_bank_r <= '0;
            deq_bank_r <= '0;
            occ_r      <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            bank_q     <= bank_nxt;
            enq_bank_r <= bank_nxt[enq_bank_idx];
            srt_bank_r <= bank_nxt[srt_bank_idx];
            deq_bank_r <= bank_nxt[deq_bank_idx];
            occ_r      <= occ_nxt;
            empty_r    <= (occ_nxt == '0);
            full_r     <= (occ_nxt == (IW+1)'(BANKS_N));
            err_r      <= err_r | err_set;
        end
    end

endmodule

// File: tb/tb_qs_bank_sched.sv
// tb_qs_bank_sched: directed lifecycle scenarios plus randomized traffic
// checked against a per-bank reference model.
module tb_qs_bank_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  enq_bank_idx, srt_bank_idx, deq_bank_idx;
    logic        enq_upd_vld, srt_upd_vld, deq_upd_vld;
    logic [13:0] enq_upd, srt_upd, deq_upd;
    logic [13:0] enq_bank_r, srt_bank_r, deq_bank_r;
    logic [2:0]  occ_r;
    logic        empty_r, full_r, err_r;

    int checks = 0;
    int errors = 0;

    logic [13:0] m_bank [4];
    bit          m_err;
    int          m_occ;
    logic [13:0] exp_r [3];

    always #5 clk = ~clk;

    qs_bank_sched dut (
        .clk          (clk),
        .rst          (rst),
        .enq_bank_idx (enq_bank_idx),
        .srt_bank_idx (srt_bank_idx),
        .deq_bank_idx (deq_bank_idx),
        .enq_upd_vld  (enq_upd_vld),
        .srt_upd_vld  (srt_upd_vld),
        .deq_upd_vld  (deq_upd_vld),
        .enq_upd      (enq_upd),
        .srt_upd      (srt_upd),
        .deq_upd      (deq_upd),
        .enq_bank_r   (enq_bank_r),
        .srt_bank_r   (srt_bank_r),
        .deq_bank_r   (deq_bank_r),
        .occ_r        (occ_r),
        .empty_r      (empty_r),
        .full_r       (full_r),
        .err_r        (err_r)
    );

    function automatic logic [13:0] mk(input int s, input int n);
        logic [13:0] r;
        r = {1'b0, n[9:0], s[2:0]};
        return r;
    endfunction

    // agent 0 = deq, 1 = srt, 2 = enq (also the priority order)
    function automatic bit legal(input int a, input int from, input int to);
        if (to > 5) return 1'b0;
`ifdef QS_BANK_SCHED_LEGAL_CHK_EN
        if (a == 2) return (from == 0 && to == 1) || (from == 1 && to == 2);
        if (a == 1) return (from == 2 && to == 3) || (from == 3 && to == 4);
        return (from == 4 && to == 5) || (from == 5 && to == 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic drv(input int a, input int idx, input int st, input int n);
        if (a == 0) begin
            deq_upd_vld = 1'b1; deq_bank_idx = idx[1:0]; deq_upd = mk(st, n);
        end else if (a == 1) begin
            srt_upd_vld = 1'b1; srt_bank_idx = idx[1:0]; srt_upd = mk(st, n);
        end else begin
            enq_upd_vld = 1'b1; enq_bank_idx = idx[1:0]; enq_upd = mk(st, n);
        end
    endtask

    task automatic sel(input int idx);
        enq_bank_idx = idx[1:0];
        srt_bank_idx = idx[1:0];
        deq_bank_idx = idx[1:0];
    endtask

    // One clock: model computes next state from the driven inputs.
    task automatic step();
        logic [13:0] nb [4];
        bit          e;
        int          vl [3];
        int          ix [3];
        logic [13:0] up [3];
        int          cnt, win;
        vl[0] = deq_upd_vld; ix[0] = deq_bank_idx; up[0] = deq_upd;
        vl[1] = srt_upd_vld; ix[1] = srt_bank_idx; up[1] = srt_upd;
        vl[2] = enq_upd_vld; ix[2] = enq_bank_idx; up[2] = enq_upd;
        e = m_err;
        for (int b = 0; b < 4; b++) nb[b] = m_bank[b];
        if (rst) begin
            for (int b = 0; b < 4; b++) nb[b] = '0;
            e = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt = 0; win = -1;
                for (int a = 0; a < 3; a++)
                    if (vl[a] != 0 && ix[a] == b) begin
                        cnt++;
                        if (win < 0) win = a;
                    end
                if (cnt > 1) e = 1'b1;
                if (win >= 0) begin
                    if (legal(win, int'(m_bank[b][2:0]), int'(up[win][2:0])))
                        nb[b] = up[win];
                    else
                        e = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_occ = 0;
        for (int b = 0; b < 4; b++) begin
            m_bank[b] = nb[b];
            if (nb[b][2:0] != 3'd0) m_occ++;
        end
        m_err = e;
        exp_r[0] = nb[ix[0]];
        exp_r[1] = nb[ix[1]];
        exp_r[2] = nb[ix[2]];
        enq_upd_vld = 1'b0;
        srt_upd_vld = 1'b0;
        deq_upd_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel(1);
        drv(2, 1, 1, 5);
        do_reset();
        checks++;
        if (enq_bank_r !== 14'd0 || srt_bank_r !== 14'd0 || deq_bank_r !== 14'd0) begin
            errors++;
            $display("FAIL reset_bank_r: got %h/%h/%h want 0", enq_bank_r, srt_bank_r, deq_bank_r);
        end
        checks++;
        if ({occ_r, empty_r, full_r, err_r} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got occ=%0d e=%b f=%b err=%b want 0 1 0 0",
                     occ_r, empty_r, full_r, err_r);
        end
    endtask

    task automatic test_lifecycle();
        int ag [6] = '{2, 2, 1, 1, 0, 0};
        int st [6] = '{1, 2, 3, 4, 5, 0};
        int occ_w [6] = '{1, 1, 1, 1, 1, 0};
        do_reset();
        sel(1);
        for (int i = 0; i < 6; i++) begin
            drv(ag[i], 1, st[i], 7);
            step();
            checks++;
            if (srt_bank_r !== mk(st[i], 7) || enq_bank_r !== mk(st[i], 7)) begin
                errors++;
                $display("FAIL life_state%0d: got %h want %h", i, srt_bank_r, mk(st[i], 7));
            end
            checks++;
            if (occ_r !== 3'(occ_w[i]) || err_r !== 1'b0) begin
                errors++;
                $display("FAIL life_occ%0d: got occ=%0d err=%b want %0d 0",
                         i, occ_r, err_r, occ_w[i]);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drv(2, b, 1, b);
            step();
            checks++;
            if (occ_r !== 3'(b + 1) || full_r !== (b == 3) || empty_r !== 1'b0) begin
                errors++;
                $display("FAIL fill_occ%0d: got occ=%0d full=%b empty=%b want %0d %b 0",
                         b, occ_r, full_r, empty_r, b + 1, b == 3);
            end
        end
        drv(2, 0, 2, 0); step();
        drv(1, 0, 3, 0); step();
        drv(1, 0, 4, 0); step();
        drv(0, 0, 5, 0); step();
        drv(0, 0, 0, 0); step();
        checks++;
        if (occ_r !== 3'd3 || full_r !== 1'b0 || err_r !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: got occ=%0d full=%b err=%b want 3 0 0",
                     occ_r, full_r, err_r);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        sel(2);
        drv(2, 2, 1, 3); step();
        drv(2, 2, 2, 3); step();
        drv(1, 2, 3, 3); step();
        drv(1, 2, 4, 9);
        drv(2, 2, 1, 1);
        step();
        checks++;
        if (deq_bank_r !== mk(4, 9) || err_r !== 1'b1) begin
            errors++;
            $display("FAIL conflict: got %h err=%b want %h 1", deq_bank_r, err_r, mk(4, 9));
        end
    endtask

    task automatic test_illegal();
        do_reset();
        sel(3);
        drv(2, 3, 2, 4);
        step();
        checks++;
`ifdef QS_BANK_SCHED_LEGAL_CHK_EN
        if (enq_bank_r !== 14'd0 || err_r !== 1'b1) begin
            errors++;
            $display("FAIL illegal_skip: got %h err=%b want 0 1", enq_bank_r, err_r);
        end
`else
        if (enq_bank_r !== mk(2, 4) || err_r !== 1'b0) begin
            errors++;
            $display("FAIL illegal_skip: got %h err=%b want %h 0", enq_bank_r, err_r, mk(2, 4));
        end
`endif
    endtask

    task automatic test_status7();
        do_reset();
        sel(0);
        drv(0, 0, 7, 1);
        step();
        checks++;
        if (deq_bank_r !== 14'd0 || err_r !== 1'b1 || occ_r !== 3'd0) begin
            errors++;
            $display("FAIL status7: got %h err=%b occ=%0d want 0 1 0", deq_bank_r, err_r, occ_r);
        end
        step();
        checks++;
        if (err_r !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err_r);
        end
    endtask

    task automatic test_reset_mid();
        int st2 [5] = '{1, 2, 3, 4, 5};
        int ag2 [5] = '{2, 2, 1, 1, 0};
        do_reset();
        drv(2, 0, 1, 1); step();
        for (int i = 0; i < 5; i++) begin
            drv(ag2[i], 2, st2[i], 2);
            if (i < 3) drv(ag2[i] == 0 ? 1 : (ag2[i] == 1 ? 0 : 1), 1,
                           i == 0 ? 0 : 0, 0);
            step();
        end
        do_reset();
        drv(2, 0, 1, 1); drv(1, 1, 2, 1); drv(0, 2, 3, 1);
        do_reset();
        drv(2, 1, 1, 1); step();
        drv(2, 1, 2, 1); step();
        drv(1, 1, 3, 1); step();
        drv(2, 0, 1, 1); step();
        checks++;
        if (occ_r !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre: got occ=%0d want 2", occ_r);
        end
        for (int i = 0; i < 5; i++) begin
            drv(ag2[i], 2, st2[i], 2);
            step();
        end
        checks++;
        if (occ_r !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre3: got occ=%0d want 3", occ_r);
        end
        rst = 1'b1;
        drv(0, 2, 0, 0);
        drv(2, 3, 1, 0);
        step();
        rst = 1'b0;
        checks++;
        if (occ_r !== 3'd0 || empty_r !== 1'b1 || err_r !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got occ=%0d empty=%b err=%b want 0 1 0", occ_r, empty_r, err_r);
        end
        for (int b = 0; b < 4; b++) begin
            sel(b);
            step();
            checks++;
            if (enq_bank_r !== 14'd0) begin
                errors++;
                $display("FAIL mid_idle%0d: got %h want 0", b, enq_bank_r);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] got [3];
        int idx, s;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int a = 0; a < 3; a++) begin
                idx = $urandom_range(0, 3);
                if ($urandom_range(0, 3) != 0)
                    s = (int'(m_bank[idx][2:0]) + 1) % 6;
                else
                    s = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1)
                    drv(a, idx, s, $urandom_range(0, 1023));
                else if (a == 0) deq_bank_idx = 2'(idx);
                else if (a == 1) srt_bank_idx = 2'(idx);
                else enq_bank_idx = 2'(idx);
            end
            step();
            rst = 1'b0;
            got[0] = deq_bank_r; got[1] = srt_bank_r; got[2] = enq_bank_r;
            for (int a = 0; a < 3; a++) begin
                checks++;
                if (got[a] !== exp_r[a]) begin
                    errors++;
                    $display("FAIL rand_bank_r%0d cyc %0d: got %h want %h", a, c, got[a], exp_r[a]);
                end
            end
            checks++;
            if (occ_r !== 3'(m_occ) || empty_r !== (m_occ == 0) ||
                full_r !== (m_occ == 4) || err_r !== m_err) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: got occ=%0d e=%b f=%b err=%b want %0d %b %b %b",
                         c, occ_r, empty_r, full_r, err_r,
                         m_occ, m_occ == 0, m_occ == 4, m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        enq_upd_vld = 1'b0; srt_upd_vld = 1'b0; deq_upd_vld = 1'b0;
        enq_upd = '0; srt_upd = '0; deq_upd = '0;
        sel(0);
        m_err = 1'b0;
        m_occ = 0;
        for (int b = 0; b < 4; b++) m_bank[b] = '0;
        @(negedge clk);
        test_reset();
        test_lifecycle();
        test_fill();
        test_conflict();
        test_illegal();
        test_status7();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qs_bank_sched.md
QS_BANK_SCHED -- requirements
Module: qs_bank_sched

Interface
REQ-001 The block SHALL have parameter BANKS_N, default 4, giving the number of banks (power of two, >=2); bank_id_t is log2(BANKS_N) bits.
REQ-002 The block SHALL have parameter N_W, default 10, giving the entry-count width; bank_state_t SHALL be packed {err 1b, n N_W b, status 3b}, 14 bits at defaults.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enq_bank_idx / srt_bank_idx / deq_bank_idx  in  log2(BANKS_N) each  bank selected by the enqueue, sort and dequeue agents.
REQ-007 enq_upd_vld / srt_upd_vld / deq_upd_vld  in  1 each  agent requests a state update of its selected bank.
REQ-008 enq_upd / srt_upd / deq_upd  in  bank_state_t each  new bank state.
REQ-009 enq_bank_r / srt_bank_r / deq_bank_r  out  bank_state_t each  registered state of each agent's selected bank.
REQ-010 occ_r  out  log2(BANKS_N)+1  count of banks not in IDLE.
REQ-011 empty_r / full_r  out  1 each  occ_r==0 / occ_r==BANKS_N.
REQ-012 err_r  out  1  sticky protocol-error flag.

Function
REQ-013 Status encoding SHALL be IDLE=0, LOADING=1, READY=2, SORTING=3, SORTED=4, UNLOADING=5; codes 6-7 are illegal.
REQ-014 Each bank SHALL hold a bank_state_t register; per-bank lifecycle SHALL be IDLE->LOADING->READY->SORTING->SORTED->UNLOADING->IDLE.
REQ-015 Legal writers: enq for IDLE->LOADING and LOADING->READY; srt for READY->SORTING and SORTING->SORTED; deq for SORTED->UNLOADING and UNLOADING->IDLE.
REQ-016 An accepted update SHALL overwrite the whole bank_state_t (status, n, err) at the next clock edge.
REQ-017 When two or more agents update the same bank in one cycle, priority SHALL be deq > srt > enq; losers SHALL be dropped and err_r set.
REQ-018 Updates to distinct banks in the same cycle SHALL all be accepted.
REQ-019 *_bank_r SHALL be registered from next-state: an update accepted in cycle t is visible on every *_bank_r selecting that bank in cycle t+1.
REQ-020 Read latency SHALL be one cycle: an index presented in cycle t is reflected on *_bank_r in cycle t+1.
REQ-021 occ_r SHALL update in the same cycle as the status change: +1 per IDLE->non-IDLE transition and -1 per non-IDLE->IDLE transition, with the net change applied when several transitions occur in one cycle.
REQ-022 occ_r SHALL never wrap; empty_r and full_r SHALL be registered and consistent with occ_r in the same cycle.
REQ-023 err_r, once set, SHALL remain set until rst.
REQ-024 An update whose new status is 6 or 7 SHALL be dropped and SHALL set err_r in every build.

Reset
REQ-025 On rst, all banks SHALL be set to {err 0, n 0, status IDLE}.
REQ-026 On rst, *_bank_r SHALL be 0, occ_r 0, empty_r 1, full_r 0 and err_r 0, from the first cycle after the reset edge.
REQ-027 Updates presented while rst is high SHALL be ignored; rst asserted mid-lifecycle SHALL return every bank to IDLE.

Configuration
REQ-028 Macro QS_BANK_SCHED_LEGAL_CHK_EN SHALL gate transition checking.
REQ-029 With QS_BANK_SCHED_LEGAL_CHK_EN defined, any update that is not a legal transition for that writer per REQ-015 SHALL be dropped (bank unchanged) and SHALL set err_r.
REQ-030 Without the macro, every update with status 0-5 SHALL be accepted regardless of writer or current status; REQ-017 and REQ-024 still apply.

Verification
REQ-031 Full lifecycle on bank 1: enq IDLE->LOADING, enq READY n=7, srt SORTING, srt SORTED, deq UNLOADING, deq IDLE -> each state appears on *_bank_r one cycle after its update; occ_r goes 0->1->0; err_r stays 0.
REQ-032 Fill all 4 banks to LOADING in consecutive cycles -> occ_r reads 1,2,3,4; full_r=1 in the same cycle occ_r=4; then deq returns bank 0 to IDLE -> occ_r=3, full_r=0.
REQ-033 In one cycle, srt writes SORTED and enq writes LOADING to bank 2 (in SORTING) -> bank 2 becomes SORTED; err_r=1 the next cycle.
REQ-034 With LEGAL_CHK_EN defined, enq writes READY to an IDLE bank -> bank stays IDLE and err_r=1; without the macro, the bank becomes READY and err_r=0.
REQ-035 Status 7 written by deq -> write dropped and err_r=1 in both builds.
REQ-036 rst asserted with banks in LOADING, SORTING and UNLOADING -> the next cycle shows all banks IDLE, occ_r=0, empty_r=1, err_r=0.
